// File: rtl/tile_map_writer_pkg.sv
// Geometry and state encoding for the tile screen RAM. The writer and the raster
// read path both import this package so they share one set of geometry constants.
package tile_map_writer_pkg;

   localparam int COLS  = 80;
   localparam int ROWS  = 60;
   localparam int AW    = 13;
   localparam int TW    = 4;
   localparam int CELLS = COLS * ROWS;

   localparam logic [TW-1:0] TILE_BLANK = 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FILL  = 2'd2
   } state_e;

endpackage

// File: rtl/tile_map_writer_if.sv
// Request bus from the game/CPU side and write port B of the screen RAM.
interface tmw_req_if #(parameter int TW = 4);
   logic          req_valid;
   logic          req_ready;
   logic [6:0]    req_col;
   logic [5:0]    req_row;
   logic [TW-1:0] req_tile;

   modport master (output req_valid, req_col, req_row, req_tile, input req_ready);
   modport slave  (input req_valid, req_col, req_row, req_tile, output req_ready);
endinterface

interface tmw_ram_if #(parameter int AW = 13, parameter int TW = 4);
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [TW-1:0] ram_din;

   modport master (output ram_we, ram_addr, ram_din);
   modport slave  (input ram_we, ram_addr, ram_din);
endinterface

// File: rtl/tile_map_writer_tile_addr_calc.sv
// Combinational row*COLS+col via shifts (COLS=80 = 64+16) plus a range check.
module tile_addr_calc #(
   parameter int COLS = tile_map_writer_pkg::COLS,
   parameter int ROWS = tile_map_writer_pkg::ROWS,
   parameter int AW   = tile_map_writer_pkg::AW
) (
   input  logic [6:0]    col_i,
   input  logic [5:0]    row_i,
   output logic [AW-1:0] addr_o,
   output logic          in_range_o
);
   import tile_map_writer_pkg::*;

   assign addr_o     = (AW'(row_i) << 6) + (AW'(row_i) << 4) + AW'(col_i);
   assign in_range_o = (int'(col_i) < COLS) && (int'(row_i) < ROWS);

endmodule

// File: rtl/tile_map_writer.sv
// Port-B write master for the tile screen RAM: single-tile writes and full-screen
// fills, optionally held off until the display is blanked.
module tile_map_writer #(
   parameter int COLS       = tile_map_writer_pkg::COLS,
   parameter int ROWS       = tile_map_writer_pkg::ROWS,
   parameter int AW         = tile_map_writer_pkg::AW,
   parameter int TW         = tile_map_writer_pkg::TW,
   parameter bit BLANK_ONLY = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          bright,
   input  logic          fill_start,
   input  logic [TW-1:0] fill_tile,
   output logic          busy,
   output logic          done,
   output logic          err,
   tmw_req_if.slave      req,
   tmw_ram_if.master     ram
);
   import tile_map_writer_pkg::*;

   localparam logic [AW-1:0] LAST = AW'(COLS * ROWS - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d, cnt_q, cnt_d, last_addr_q;
   logic [TW-1:0] tile_q, tile_d, last_din_q;
   logic          live_q, done_q, done_d, err_q, err_d;
   logic [AW-1:0] calc_addr, cur_addr;
   logic [TW-1:0] cur_din;
   logic          in_range, slot, we;

   // A write may issue this cycle unless writes are confined to blanking.
   assign slot = !BLANK_ONLY || !bright;

   tile_addr_calc #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_calc (
      .col_i      (req.req_col),
      .row_i      (req.req_row),
      .addr_o     (calc_addr),
      .in_range_o (in_range)
   );

   always_comb begin
      state_d       = state_q;
      wr_addr_d     = wr_addr_q;
      tile_d        = tile_q;
      cnt_d         = cnt_q;
      done_d        = 1'b0;
      err_d         = 1'b0;
      req.req_ready = 1'b0;
      we            = 1'b0;
      cur_addr      = wr_addr_q;
      cur_din       = tile_q;
      case (state_q)
         ST_IDLE: if (live_q) begin
            // A fill outranks a coincident request, which stays unconsumed.
            if (fill_start) begin
               state_d = ST_FILL;
               tile_d  = fill_tile;
               cnt_d   = '0;
            end else begin
               req.req_ready = 1'b1;
               if (req.req_valid) begin
                  if (in_range) begin
                     wr_addr_d = calc_addr;
                     tile_d    = req.req_tile;
                     state_d   = ST_WRITE;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         ST_WRITE: if (slot) begin
            we      = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_FILL: begin
            cur_addr = cnt_q;
            if (slot) begin
               we = 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + AW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_addr_q   <= '0;
         cnt_q       <= '0;
         tile_q      <= '0;
         last_addr_q <= '0;
         last_din_q  <= '0;
         live_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         cnt_q     <= cnt_d;
         tile_q    <= tile_d;
         live_q    <= 1'b1;
         done_q    <= done_d;
         err_q     <= err_d;
         if (we) begin
            last_addr_q <= cur_addr;
            last_din_q  <= cur_din;
         end
      end
   end

   // Address/data only move when a write is actually issued.
   assign ram.ram_we   = we;
   assign ram.ram_addr = we ? cur_addr : last_addr_q;
   assign ram.ram_din  = we ? cur_din  : last_din_q;

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: doc/tile_map_writer.md
Name: tile_map_writer

Overview:
- Write-side master for the 80x60 tile-index screen RAM. The existing display path reads that RAM on port A using the raster counters.
- This block drives port B: we, addr, din. It turns single-tile write requests and full-screen fill commands into RAM writes.
- Writes are optionally deferred to blanking time.
- Sits between the game/CPU logic and the screen RAM.

Parameters:
- COLS, 80, tiles per row
- ROWS, 60, tile rows
- AW, 13, RAM address width
- TW, 4, tile index width (16 tiles)
- BLANK_ONLY, 0, when 1 RAM writes are issued only while bright=0

Ports:
- clk  in  1  system clock; the RAM port B is also clocked on this clock
- rst_n  in  1  asynchronous active-low reset
- bright  in  1  active-video flag from the sync generator
- req_valid  in  1  single-tile write request
- req_ready  out  1  block can accept a request this cycle
- req_col  in  7  tile column, 0..79
- req_row  in  6  tile row, 0..59
- req_tile  in  TW  tile index to write
- fill_start  in  1  one-cycle pulse: write fill_tile to every entry
- fill_tile  in  TW  tile used by the fill
- busy  out  1  fill in progress or write pending
- done  out  1  one-cycle pulse on completion of a request or fill
- err  out  1  one-cycle pulse when a request is rejected as out of range
- ram_we  out  1  port B write enable
- ram_addr  out  AW  port B address
- ram_din  out  TW  port B write data

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0 while in reset; busy=0, done=0, err=0, ram_we=0, ram_addr=0, ram_din=0, fill counter=0. req_ready=1 from the first clock after release.
- Address arithmetic: addr = row*80 + col, computed as (row<<6)+(row<<4)+col in AW bits. No multiplier. Maximum 4799 fits 13 bits.
- States: IDLE, WRITE, FILL.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready with col<COLS and row<ROWS: latch addr/tile, go to WRITE, busy=1.
  - Out-of-range request: accepted (consumed), err=1 for one cycle, no RAM write, stay IDLE.
- WRITE:
  - req_ready=0.
  - If BLANK_ONLY=0 or bright=0: ram_we=1 for exactly one cycle, then done=1 next cycle, return to IDLE.
  - Otherwise hold and wait for bright=0.
  - Latency with BLANK_ONLY=0: handshake in cycle N, ram_we in cycle N+1, done in cycle N+2, req_ready=1 again in cycle N+2.
- FILL (from IDLE on fill_start):
  - fill_tile is latched at entry; counter starts at 0.
  - One write per eligible cycle: addr=counter, din=latched tile, counter+1.
  - With BLANK_ONLY=1, writes pause while bright=1 and the counter holds.
  - After the write at address COLS*ROWS-1 (4799): counter wraps to 0, done pulses, return to IDLE. Exactly 4800 writes, no gaps other than blanking stalls.
- Simultaneous events:
  - fill_start and req_valid in the same IDLE cycle: fill wins, req_ready=0 that cycle, and the request is not consumed.
  - fill_start while busy is ignored.
- ram_we is low in all other cycles. ram_addr/ram_din hold their last value when ram_we=0.
- Reset mid-fill: aborts immediately, with no further writes. The RAM contents are left partially filled; this is legal.
- done and err never assert in the same cycle.

Decomposition:
- Shared package/include holds: COLS, ROWS, AW, TW, TILE_BLANK=4'd0, and the state encoding localparams, so the read-side address computation uses the same geometry constants.
- One natural sub-module, tile_addr_calc: combinational row*80+col via shifts plus a range check. It is reused by the read path in future refactors.

Test Plan:
- Reset then req col=5,row=2,tile=4'h9, BLANK_ONLY=0 -> ram_we one cycle later with addr=165, din=9; done 2 cycles after the handshake.
- Req col=79,row=59,tile=4'hF -> addr=4799, din=F. Req col=80,row=0 -> err pulse, no ram_we, req_ready stays 1.
- fill_start fill_tile=4'h3, BLANK_ONLY=0 -> 4800 consecutive ram_we with addr 0..4799, din=3; done after the last write. A req_valid during the fill is not accepted.
- BLANK_ONLY=1, bright toggled 640 cycles high / 160 cycles low -> no ram_we while bright=1, the fill completes with all 4800 addresses written exactly once.
- fill_start and req_valid in the same cycle -> fill runs; the request is accepted only after the fill's done pulse.
- rst_n low at fill write 1000 -> outputs at reset values asynchronously, no writes after that; a fresh fill restarts at addr 0.
